score_award_gen: RTL and testbench

- Upstream producer for the 4-digit BCD scoreboard accumulator.
- Converts line-clear events from the Tetris playfield logic into a one-cycle BCD score increment: base points × (level+1).
- Multiplication is done by iterated 4-digit BCD addition.
- Includes a one-deep pending buffer so back-to-back clears are not lost; output is zero on every cycle it is not emitting.

---
 rtl/score_award_gen.sv | 217 +++++++++++++++++++++
 tb/tb_score_award_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_award_gen.sv
// score_award_gen: turns Tetris line-clear events into a one-cycle BCD score
// increment equal to base points x (level+1). The product is built by
// repeated 4-digit BCD addition. A one-deep pending slot holds a clear that
// arrives while an award is still in progress.
module score_award_gen #(
  parameter int unsigned BASE1 = 40,
  parameter int unsigned BASE2 = 100,
  parameter int unsigned BASE3 = 300,
  parameter int unsigned BASE4 = 1200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_valid,
  input  logic [2:0]      lines_cleared,
  input  logic [3:0]      level,
  output logic [3:0][4:0] score_to_add,
  output logic            award_valid,
  output logic            busy,
  output logic            overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_e;

  // Convert a constant decimal value into four BCD digits in 5-bit fields.
  function automatic logic [3:0][4:0] to_bcd(input int unsigned v);
    logic [3:0][4:0] r;
    int unsigned     div;
    div = 1;
    for (int i = 0; i < 4; i++) begin
      r[i] = 5'((v / div) % 10);
      div  = div * 10;
    end
    return r;
  endfunction

  // Four-digit BCD add; bit 20 is the carry out of the thousands digit.
  function automatic logic [20:0] bcd_add(input logic [3:0][4:0] a,
                                          input logic [3:0][4:0] b);
    logic [3:0][4:0] s;
    logic            c;
    logic [4:0]      t;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = a[i] + b[i] + {4'd0, c};
      if (t > 5'd9) begin
        s[i] = t - 5'd10;
        c    = 1'b1;
      end else begin
        s[i] = t;
        c    = 1'b0;
      end
    end
    return {c, s};
  endfunction

  localparam logic [3:0][4:0] BCD1 = to_bcd(BASE1);
  localparam logic [3:0][4:0] BCD2 = to_bcd(BASE2);
  localparam logic [3:0][4:0] BCD3 = to_bcd(BASE3);
  localparam logic [3:0][4:0] BCD4 = to_bcd(BASE4);
  localparam logic [3:0][4:0] BCD_MAX = {5'd9, 5'd9, 5'd9, 5'd9};

  // Base points for a given line count (only 1..4 ever reach this).
  function automatic logic [3:0][4:0] base_sel(input logic [2:0] lines);
    logic [3:0][4:0] r;
    case (lines)
      3'd1:    r = BCD1;
      3'd2:    r = BCD2;
      3'd3:    r = BCD3;
      3'd4:    r = BCD4;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [3:0][4:0] acc_q, acc_d;
  logic [3:0][4:0] base_q, base_d;
  logic [3:0]      count_q, count_d;
  logic            sat_q, sat_d;
  logic            pend_valid_q, pend_valid_d;
  logic [2:0]      pend_lines_q, pend_lines_d;
  logic [3:0]      pend_level_q, pend_level_d;
  logic            ovf_q, ovf_d;

  logic            event_s;
  logic            drain_s;
  logic [20:0]     sum_s;
  logic [2:0]      load_lines_s;
  logic [3:0]      load_level_s;

  // Next-state, accumulation and pending-slot logic.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    base_d       = base_q;
    count_d      = count_q;
    sat_d        = sat_q;
    pend_valid_d = pend_valid_q;
    pend_lines_d = pend_lines_q;
    pend_level_d = pend_level_q;
    ovf_d        = 1'b0;

    event_s = clear_valid && (lines_cleared >= 3'd1) && (lines_cleared <= 3'd4);
    // The pending slot empties whenever no accumulation is running. IDLE
    // drains too, so a clear parked during the final EMIT (with nothing
    // pending) is still served one cycle later instead of being stranded.
    drain_s = pend_valid_q && (state_q != S_ACCUM);
    sum_s   = bcd_add(acc_q, base_q);

    if (drain_s) begin
      load_lines_s = pend_lines_q;
      load_level_s = pend_level_q;
    end else begin
      load_lines_s = lines_cleared;
      load_level_s = level;
    end

    case (state_q)
      S_IDLE: begin
        if (drain_s || event_s) begin
          base_d  = base_sel(load_lines_s);
          count_d = load_level_s;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        acc_d = sum_s[19:0];
        sat_d = sat_q | sum_s[20];
        if (count_q == 4'd0) begin
          state_d = S_EMIT;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_EMIT: begin
        if (drain_s) begin
          base_d  = base_sel(load_lines_s);
          count_d = load_level_s;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (drain_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    if (event_s) begin
      if ((state_q == S_IDLE) && !pend_valid_q) begin
        pend_valid_d = pend_valid_d;  // taken straight into ACCUM above
      end else if (!pend_valid_q || drain_s) begin
        pend_valid_d = 1'b1;
        pend_lines_d = lines_cleared;
        pend_level_d = level;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any award in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      base_q       <= '0;
      count_q      <= 4'd0;
      sat_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_lines_q <= 3'd0;
      pend_level_q <= 4'd0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      base_q       <= base_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      pend_valid_q <= pend_valid_d;
      pend_lines_q <= pend_lines_d;
      pend_level_q <= pend_level_d;
      ovf_q        <= ovf_d;
    end
  end

  // Outputs decoded from registered state only; zero outside EMIT.
  always_comb begin
    award_valid = (state_q == S_EMIT);
    busy        = (state_q != S_IDLE);
    overflow    = ovf_q;
    if (state_q == S_EMIT) begin
      score_to_add = sat_q ? BCD_MAX : acc_q;
    end else begin
      score_to_add = '0;
    end
  end

endmodule

// File: tb/tb_score_award_gen.sv
// Scoreboard bench for score_award_gen: a timeline reference model predicts
// the edge of each award and each overflow; a monitor compares every cycle.
module tb_score_award_gen;

  logic            clk;
  logic            reset;
  logic            clear_valid;
  logic [2:0]      lines_cleared;
  logic [3:0]      level;
  logic [3:0][4:0] score_to_add;
  logic            award_valid;
  logic            busy;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  score_award_gen dut (
    .clk          (clk),
    .reset        (reset),
    .clear_valid  (clear_valid),
    .lines_cleared(lines_cleared),
    .level        (level),
    .score_to_add (score_to_add),
    .award_valid  (award_valid),
    .busy         (busy),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              e;
    logic [3:0][4:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   ovf_q[$];

  // Reference model state: the job in progress finishes (EMIT) at edge job_emit.
  int         edge_n = 0;
  bit         has_job = 0;
  int         job_emit = 0;
  bit         pend_v = 0;
  int         pend_l = 0;
  int         pend_lv = 0;

  function automatic logic [3:0][4:0] award_digits(input int l, input int lv);
    int              v;
    int              div;
    logic [3:0][4:0] r;
    case (l)
      1:       v = 40;
      2:       v = 100;
      3:       v = 300;
      default: v = 1200;
    endcase
    v = v * (lv + 1);
    if (v > 9999) v = 9999;
    div = 1;
    for (int i = 0; i < 4; i++) begin
      r[i] = 5'((v / div) % 10);
      div  = div * 10;
    end
    return r;
  endfunction

  task automatic start_job(input int l, input int lv);
    exp_t x;
    has_job  = 1;
    job_emit = edge_n + lv + 2;
    x.e = job_emit;
    x.d = award_digits(l, lv);
    exp_q.push_back(x);
  endtask

  // Reference model: evaluated on each rising edge with the sampled inputs.
  always @(posedge clk) begin
    bit ev, idle, in_emit, accum, drain, old_pv;
    edge_n = edge_n + 1;
    if (!reset) begin
      has_job = 0;
      pend_v  = 0;
      exp_q.delete();
      ovf_q.delete();
    end else begin
      ev      = clear_valid && (lines_cleared >= 1) && (lines_cleared <= 4);
      idle    = !has_job;
      in_emit = has_job && (job_emit == edge_n);
      accum   = has_job && (job_emit > edge_n);
      old_pv  = pend_v;
      drain   = old_pv && !accum;
      if (drain) begin
        pend_v = 0;
        start_job(pend_l, pend_lv);
      end else if (in_emit) begin
        has_job = 0;
      end
      if (ev) begin
        if (idle && !old_pv) begin
          start_job(int'(lines_cleared), int'(level));
        end else if (!old_pv || drain) begin
          pend_v  = 1;
          pend_l  = int'(lines_cleared);
          pend_lv = int'(level);
        end else begin
          ovf_q.push_back(edge_n);
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the scoreboard queues.
  always @(negedge clk) begin
    exp_t f;
    bit   exp_ovf;
    if (reset) begin
      if (award_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL award_unexpected: got %h at edge %0d, none expected", score_to_add, edge_n + 1);
        end else begin
          f = exp_q.pop_front();
          if (f.d !== score_to_add || f.e != edge_n + 1) begin
            errors++;
            $display("FAIL award: got %h at edge %0d, required %h at edge %0d", score_to_add, edge_n + 1, f.d, f.e);
          end
        end
      end else begin
        checks++;
        if (score_to_add !== '0) begin
          errors++;
          $display("FAIL score_idle: got %h, required 0", score_to_add);
        end
        if (exp_q.size() != 0 && exp_q[0].e <= edge_n + 1) begin
          f = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL award_missing: got none, required %h at edge %0d", f.d, f.e);
        end
      end
      exp_ovf = (ovf_q.size() != 0 && ovf_q[0] == edge_n);
      if (exp_ovf) void'(ovf_q.pop_front());
      checks++;
      if (overflow !== exp_ovf) begin
        errors++;
        $display("FAIL overflow: got %b, required %b at edge %0d", overflow, exp_ovf, edge_n);
      end
      checks++;
      if (busy !== has_job) begin
        errors++;
        $display("FAIL busy: got %b, required %b at edge %0d", busy, has_job, edge_n);
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] l, input logic [3:0] lv);
    @(negedge clk);
    clear_valid   = v;
    lines_cleared = l;
    level         = lv;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 3'd0, 4'd0);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (score_to_add !== '0 || award_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: got score=%h av=%b busy=%b ovf=%b, required all 0",
               nm, score_to_add, award_valid, busy, overflow);
    end
  endtask

  initial begin
    reset         = 1'b0;
    clear_valid   = 1'b0;
    lines_cleared = 3'd0;
    level         = 4'd0;
    #1;
    check_zero("reset_state");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    idle_n(2);
    // single award 40
    drive(1'b1, 3'd1, 4'd0); idle_n(5);
    // level multiplier: 300 x 3 = 900
    drive(1'b1, 3'd3, 4'd2); idle_n(8);
    // saturation: 12000 and 10800 both clamp to 9999
    drive(1'b1, 3'd4, 4'd9); idle_n(14);
    drive(1'b1, 3'd4, 4'd8); idle_n(14);
    // third clear lands while the first is still accumulating: overflow
    drive(1'b1, 3'd1, 4'd1); drive(1'b1, 3'd2, 4'd0); drive(1'b1, 3'd3, 4'd0); idle_n(12);
    // third clear lands on EMIT while pending drains: no overflow
    drive(1'b1, 3'd1, 4'd0); drive(1'b1, 3'd2, 4'd0); drive(1'b1, 3'd3, 4'd0); idle_n(12);
    // clear arriving on EMIT with nothing pending
    drive(1'b1, 3'd1, 4'd0); idle_n(1); drive(1'b1, 3'd2, 4'd1); idle_n(10);
    // invalid line counts are ignored
    drive(1'b1, 3'd0, 4'd3); drive(1'b1, 3'd5, 4'd3); drive(1'b1, 3'd7, 4'd0); idle_n(3);
    // reset during ACCUM abandons the award
    drive(1'b1, 3'd4, 4'd5); idle_n(2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("reset_mid_op");
    @(negedge clk);
    #2 reset = 1'b1;
    drive(1'b1, 3'd1, 4'd0); idle_n(5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b1, 3'($urandom_range(0, 7)),
              ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)));
      end else begin
        drive(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end
    end
    idle_n(60);

    checks++;
    if (exp_q.size() != 0 || ovf_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d awards and %0d overflows outstanding, required 0",
               exp_q.size(), ovf_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
